// File: rtl/sync_multi_chan.sv
// sync_multi_chan: multi-channel conditioner for asynchronous level inputs.
// Each channel runs a STAGES-deep synchronizer, a FILT-cycle stability
// filter, a per-channel edge selector and a sticky event flag with a
// synchronous software clear. Everything lives in the clk_dst domain.
module sync_multi_chan #(
  parameter int                 NCH      = 4,
  parameter int                 STAGES   = 2,
  parameter int                 FILT     = 3,
  parameter logic [2*NCH-1:0]   MODE_VEC = '0
) (
  input  logic           clk_dst,
  input  logic           wr_rst,
  input  logic [NCH-1:0] async_in,
  input  logic [NCH-1:0] sticky_clr,
  output logic [NCH-1:0] level_out,
  output logic [NCH-1:0] pulse_out,
  output logic [NCH-1:0] sticky_out,
  output logic           any_event
);

  localparam int            CW       = $clog2(FILT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILT - 1);

  logic [NCH-1:0] sync_q [STAGES];
  logic [NCH-1:0] sync_last;
  logic [CW-1:0]  cnt_q  [NCH];
  logic [CW-1:0]  cnt_d  [NCH];
  logic [NCH-1:0] filt_q, filt_d;
  logic [NCH-1:0] prev_q;
  logic [NCH-1:0] pulse_q;
  logic [NCH-1:0] sticky_q, sticky_d;
  logic [NCH-1:0] rise, fall, sel_edge;

  // Synchronizer chain; stage 0 is the only flop that samples async_in.
  always_ff @(posedge clk_dst or posedge wr_rst) begin
    if (wr_rst) begin
      for (int k = 0; k < STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= async_in;
      for (int k = 1; k < STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign sync_last = sync_q[STAGES-1];

  // Stability filter: the level only moves after FILT consecutive
  // disagreeing cycles; any agreement restarts the count.
  always_comb begin
    filt_d = filt_q;
    for (int i = 0; i < NCH; i++) begin
      cnt_d[i] = '0;
      if (sync_last[i] != filt_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          filt_d[i] = sync_last[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  // Edge selection per channel: 00 rise, 01 fall, 10 both, 11 none.
  always_comb begin
    rise     = filt_q & ~prev_q;
    fall     = ~filt_q & prev_q;
    sel_edge = '0;
    for (int i = 0; i < NCH; i++) begin
      unique case (MODE_VEC[2*i +: 2])
        2'b00:   sel_edge[i] = rise[i];
        2'b01:   sel_edge[i] = fall[i];
        2'b10:   sel_edge[i] = rise[i] | fall[i];
        default: sel_edge[i] = 1'b0;
      endcase
    end
    sticky_d = (sticky_q & ~sticky_clr) | sel_edge;
  end

  // Filter, edge history, pulse and sticky state; set beats clear.
  always_ff @(posedge clk_dst or posedge wr_rst) begin
    if (wr_rst) begin
      for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
      filt_q   <= '0;
      prev_q   <= '0;
      pulse_q  <= '0;
      sticky_q <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) cnt_q[i] <= cnt_d[i];
      filt_q   <= filt_d;
      prev_q   <= filt_q;
      pulse_q  <= sel_edge;
      sticky_q <= sticky_d;
    end
  end

  assign level_out  = filt_q;
  assign pulse_out  = pulse_q;
  assign sticky_out = sticky_q;
  assign any_event  = |sticky_q;

endmodule

// File: tb/tb_sync_multi_chan.sv
// tb_sync_multi_chan: directed table plus hand-written sequences and a
// windowed reference model for randomly toggled inputs.
module tb_sync_multi_chan;

  logic       clk_dst;
  logic       wr_rst;
  logic [3:0] async_in;
  logic [3:0] sticky_clr;
  logic [3:0] level_out;
  logic [3:0] pulse_out;
  logic [3:0] sticky_out;
  logic       any_event;

  int checks = 0;
  int errors = 0;

  // ch0 rise, ch1 fall, ch2 both, ch3 none
  localparam logic [3:0] RISE_MASK = 4'b0101;
  localparam logic [3:0] FALL_MASK = 4'b0110;

  typedef struct {
    logic [3:0] inVal;
    logic [3:0] clrVal;
    logic [3:0] expLevel;
    logic [3:0] expPulse;
    logic [3:0] expSticky;
  } vec_t;

  vec_t vecs [20];

  sync_multi_chan #(
    .NCH(4), .STAGES(2), .FILT(3), .MODE_VEC(8'b11_10_01_00)
  ) dut (
    .clk_dst   (clk_dst),
    .wr_rst    (wr_rst),
    .async_in  (async_in),
    .sticky_clr(sticky_clr),
    .level_out (level_out),
    .pulse_out (pulse_out),
    .sticky_out(sticky_out),
    .any_event (any_event)
  );

  // Free-running destination clock.
  initial begin
    clk_dst = 1'b0;
    forever #5 clk_dst = ~clk_dst;
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  task automatic applyStimulus(input logic [3:0] inVal, input logic [3:0] clrVal);
    async_in   = inVal;
    sticky_clr = clrVal;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_dst);
    #1;
  endtask

  task automatic checkAll(input string name, input logic [3:0] lv, input logic [3:0] pu,
                          input logic [3:0] st);
    checkOutput({name, " level"},  level_out,  lv);
    checkOutput({name, " pulse"},  pulse_out,  pu);
    checkOutput({name, " sticky"}, sticky_out, st);
    checkOutput({name, " any"},    {3'b000, any_event}, {3'b000, |st});
  endtask

  task automatic pulseReset();
    #2 wr_rst = 1'b1;
    @(negedge clk_dst);
    wr_rst = 1'b0;
  endtask

  initial begin
    int pulseCnt [4];
    logic [3:0] h1, h2, h3, h4, mLevel, mPrev, mFilt, expPulse, expSticky, newIn, clr, sel;

    // ch0 rise, fall, re-rise with clear/set collision, then a lone clear
    vecs[0]  = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    vecs[1]  = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    vecs[2]  = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    vecs[3]  = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    vecs[4]  = '{4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000};
    vecs[5]  = '{4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0001};
    vecs[6]  = '{4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0001};
    vecs[7]  = '{4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0001};
    vecs[8]  = '{4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0001};
    vecs[9]  = '{4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0001};
    vecs[10] = '{4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0001};
    vecs[11] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001};
    vecs[12] = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0001};
    vecs[13] = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0001};
    vecs[14] = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0001};
    vecs[15] = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0001};
    vecs[16] = '{4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0001};
    vecs[17] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
    vecs[18] = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000};
    vecs[19] = '{4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000};

    wr_rst = 1'b1;
    applyStimulus(4'b0000, 4'b0000);
    #2;
    checkAll("reset", 4'b0000, 4'b0000, 4'b0000);
    @(negedge clk_dst);
    wr_rst = 1'b0;

    // Glitch of only two cycles must be filtered out entirely.
    for (int t = 0; t < 10; t++) begin
      applyStimulus((t < 2) ? 4'b0001 : 4'b0000, 4'b0000);
      tick();
      checkAll($sformatf("glitch t%0d", t), 4'b0000, 4'b0000, 4'b0000);
    end

    // Directed per-cycle table.
    for (int v = 0; v < 20; v++) begin
      applyStimulus(vecs[v].inVal, vecs[v].clrVal);
      tick();
      checkAll($sformatf("vec%0d", v), vecs[v].expLevel, vecs[v].expPulse, vecs[v].expSticky);
    end

    // Channels 1..3 high for 10 cycles then low; count pulses per channel.
    for (int c = 0; c < 4; c++) pulseCnt[c] = 0;
    for (int t = 1; t <= 20; t++) begin
      applyStimulus((t <= 10) ? 4'b1111 : 4'b0001, 4'b0000);
      tick();
      for (int c = 0; c < 4; c++) pulseCnt[c] += int'(pulse_out[c]);
      if (t == 4)  checkOutput("modes level before rise", level_out, 4'b0001);
      if (t == 5)  checkOutput("modes level after rise",  level_out, 4'b1111);
      if (t == 14) checkOutput("modes level before fall", level_out, 4'b1111);
      if (t == 15) checkOutput("modes level after fall",  level_out, 4'b0001);
    end
    checkOutput("ch0 pulse count", pulseCnt[0][3:0], 4'd0);
    checkOutput("ch1 pulse count", pulseCnt[1][3:0], 4'd1);
    checkOutput("ch2 pulse count", pulseCnt[2][3:0], 4'd2);
    checkOutput("ch3 pulse count", pulseCnt[3][3:0], 4'd0);
    checkOutput("modes sticky", sticky_out, 4'b0110);
    applyStimulus(4'b0001, 4'b1111);
    tick();
    checkAll("clear all", 4'b0001, 4'b0000, 4'b0000);

    // Build sticky=0101, get ch0 counter to 2, then reset asynchronously.
    for (int t = 0; t < 8; t++) begin
      applyStimulus(4'b0000, 4'b0000);
      tick();
    end
    for (int t = 0; t < 7; t++) begin
      applyStimulus(4'b0101, 4'b0000);
      tick();
    end
    checkOutput("pre-reset sticky", sticky_out, 4'b0101);
    for (int t = 0; t < 4; t++) begin
      applyStimulus(4'b0100, 4'b0000);
      tick();
    end
    checkOutput("pre-reset level", level_out, 4'b0101);
    applyStimulus(4'b0001, 4'b0000);
    #2 wr_rst = 1'b1;
    #1;
    checkAll("async reset", 4'b0000, 4'b0000, 4'b0000);
    @(negedge clk_dst);
    wr_rst = 1'b0;
    pulseCnt[0] = 0;
    for (int t = 1; t <= 10; t++) begin
      tick();
      pulseCnt[0] += int'(pulse_out[0]);
      if (t == 4) checkOutput("post-reset level e4", level_out, 4'b0000);
      if (t == 5) checkOutput("post-reset level e5", level_out, 4'b0001);
      if (t == 5) checkOutput("post-reset pulse e5", pulse_out, 4'b0000);
      if (t == 6) checkOutput("post-reset pulse e6", pulse_out, 4'b0001);
    end
    checkOutput("post-reset pulse count", pulseCnt[0][3:0], 4'd1);

    // Random toggling against a sliding-window model of the filter.
    applyStimulus(4'b0000, 4'b0000);
    pulseReset();
    {h1, h2, h3, h4, mLevel, mPrev, expPulse, expSticky} = '0;
    newIn = 4'b0000;
    for (int t = 0; t < 300; t++) begin
      for (int c = 0; c < 4; c++)
        if ($urandom_range(0, 3) == 0) newIn[c] = ~newIn[c];
      for (int c = 0; c < 4; c++) clr[c] = ($urandom_range(0, 7) == 0);
      applyStimulus(newIn, clr);
      sel       = (mLevel & ~mPrev & RISE_MASK) | (~mLevel & mPrev & FALL_MASK);
      expPulse  = sel;
      expSticky = (expSticky & ~clr) | sel;
      mFilt     = mLevel;
      for (int c = 0; c < 4; c++)
        if (h2[c] == h3[c] && h3[c] == h4[c] && h2[c] != mLevel[c]) mFilt[c] = h2[c];
      mPrev  = mLevel;
      mLevel = mFilt;
      h4 = h3; h3 = h2; h2 = h1; h1 = newIn;
      tick();
      checkAll($sformatf("rand t%0d", t), mLevel, expPulse, expSticky);
      checks++;
      if ($isunknown({level_out, pulse_out, sticky_out, any_event})) begin
        errors++;
        $display("[TB] FAIL rand x t%0d: got %b expected no X", t,
                 {level_out, pulse_out, sticky_out, any_event});
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
